xadc_scan_pwm: RTL and testbench

- Parametrised XADC DRP read sequencer with per-channel PWM brightness outputs.
- Round-robins over N_CH software-enabled aux channels. Each conversion is triggered by XADC end-of-conversion.
- Stores a 12-bit result per channel and drives one duty-cycle output per channel.
- Sits between the xadc_wiz DRP port and the board LEDs/pins. Replaces the fixed 4-channel, ready-edge-clocked logic with a single-clock, state-machine design.

---
 rtl/xadc_scan_pwm.sv | 166 ++++++++++++++++
 tb/tb_xadc_scan_pwm.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/xadc_scan_pwm.sv
// XADC DRP round-robin read sequencer with one registered PWM output per channel.
// Optional averaging of four reads per published sample: define XADC_SCAN_AVG_EN.
module xadc_scan_pwm #(
    parameter int               N_CH        = 4,
    parameter logic [N_CH*7-1:0] CH_ADDR    = {7'h16, 7'h1F, 7'h17, 7'h1E},
    parameter int               PWM_PERIOD  = 4070,
    parameter logic [11:0]      NOISE_MASK  = 12'hFF0,
    parameter int               RDY_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH-1:0]    ch_en,
    input  logic               eoc,
    output logic [6:0]         drp_daddr,
    output logic               drp_den,
    input  logic               drp_drdy,
    input  logic [15:0]        drp_do,
    output logic [12*N_CH-1:0] sample,
    output logic [N_CH-1:0]    sample_valid,
    output logic               timeout_err,
    output logic [N_CH-1:0]    pwm_out
);
    localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TW = $clog2(RDY_TIMEOUT + 1);
    localparam int PW = $clog2(PWM_PERIOD + 1);

    typedef enum logic [2:0] {IDLE, WAIT_EOC, REQ, WAIT_RDY, NEXT} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sel;
    logic [TW-1:0]   tcnt;
    logic [PW-1:0]   pcnt;
    logic            accept, tmo_hit;
    logic [3:0]      unused_do_lsbs;

    assign unused_do_lsbs = drp_do[3:0];

    function automatic logic [SW-1:0] first_set(input logic [N_CH-1:0] en);
        first_set = '0;
        for (int k = N_CH - 1; k >= 0; k--)
            if (en[k]) first_set = SW'(k);
    endfunction

    // Circular search starting after cur; lands back on cur if it is the only one set.
    function automatic logic [SW-1:0] next_set(input logic [N_CH-1:0] en, input logic [SW-1:0] cur);
        logic found;
        int   idx;
        next_set = cur;
        found    = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(cur) + k) % N_CH;
            if (!found && en[idx]) begin
                next_set = SW'(idx);
                found    = 1'b1;
            end
        end
    endfunction

    always_comb begin
        state_d = state_q;
        drp_den = 1'b0;
        accept  = 1'b0;
        tmo_hit = 1'b0;
        case (state_q)
            IDLE:     if (|ch_en) state_d = WAIT_EOC;
            WAIT_EOC: if (!(|ch_en)) state_d = IDLE;
                      else if (eoc)  state_d = REQ;
            REQ: begin
                drp_den = 1'b1;
                state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (drp_drdy) begin
                    accept  = ch_en[sel];
                    state_d = NEXT;
                end else if (int'(tcnt) == RDY_TIMEOUT - 1) begin
                    tmo_hit = 1'b1;
                    state_d = NEXT;
                end
            end
            NEXT:     state_d = (|ch_en) ? WAIT_EOC : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel         <= '0;
            drp_daddr   <= CH_ADDR[6:0];
            tcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            timeout_err <= tmo_hit;
            case (state_q)
                IDLE:     if (|ch_en) sel <= first_set(ch_en);
                WAIT_EOC: if (eoc && (|ch_en)) drp_daddr <= CH_ADDR[7*int'(sel) +: 7];
                REQ:      tcnt <= '0;
                WAIT_RDY: if (!drp_drdy) tcnt <= tcnt + 1'b1;
                NEXT:     if (|ch_en) sel <= next_set(ch_en, sel);
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || int'(pcnt) == PWM_PERIOD) pcnt <= '0;
        else                                 pcnt <= pcnt + 1'b1;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [11:0] s_q;
        logic        v_q, p_q, hit;

        assign hit = accept && (int'(sel) == i);

`ifdef XADC_SCAN_AVG_EN
        logic [13:0] acc, sum;
        logic [1:0]  rcnt;

        assign sum = acc + 14'(drp_do[15:4]);

        always_ff @(posedge clk) begin
            if (rst || !ch_en[i]) begin
                acc  <= '0;
                rcnt <= '0;
            end else if (hit) begin
                acc  <= (rcnt == 2'd3) ? 14'd0 : sum;
                rcnt <= rcnt + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s_q <= '0;
                v_q <= 1'b0;
            end else begin
                v_q <= hit && (rcnt == 2'd3);
                if (hit && (rcnt == 2'd3)) s_q <= sum[13:2];
            end
        end
`else
        always_ff @(posedge clk) begin
            if (rst) begin
                s_q <= '0;
                v_q <= 1'b0;
            end else begin
                v_q <= hit;
                if (hit) s_q <= drp_do[15:4];
            end
        end
`endif

        // Masking drops ADC noise so near-zero readings stay fully dark.
        always_ff @(posedge clk) begin
            if (rst) p_q <= 1'b0;
            else     p_q <= ch_en[i] && (int'(pcnt) < int'(s_q & NOISE_MASK));
        end

        assign sample[12*i +: 12] = s_q;
        assign sample_valid[i]    = v_q;
        assign pwm_out[i]         = p_q;
    end

endmodule

// File: tb/tb_xadc_scan_pwm.sv
// Directed bench for xadc_scan_pwm: scan order, capture, PWM duty, timeout, disable and reset.
module tb_xadc_scan_pwm;
    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ch_en;
    logic        eoc;
    logic [6:0]  drp_daddr;
    logic        drp_den;
    logic        drp_drdy;
    logic [15:0] drp_do;
    logic [47:0] sample;
    logic [3:0]  sample_valid;
    logic        timeout_err;
    logic [3:0]  pwm_out;

    int n_cmp = 0;
    int n_err = 0;

    xadc_scan_pwm dut (
        .clk(clk), .rst(rst), .ch_en(ch_en), .eoc(eoc),
        .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_drdy(drp_drdy), .drp_do(drp_do),
        .sample(sample), .sample_valid(sample_valid), .timeout_err(timeout_err), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle_then(input logic [3:0] en);
        ch_en = 4'b0;
        repeat (3) cyc();
        ch_en = en;
        cyc();
    endtask

    // One eoc-triggered read with drdy asserted lat clocks after the den cycle.
    task automatic do_read(input logic [15:0] data, input int lat, output logic [6:0] addr,
                           output logic den_ok, output logic [3:0] v1, output logic [3:0] v2);
        cyc(); cyc();
        eoc = 1'b1; cyc(); eoc = 1'b0;
        den_ok = drp_den;
        addr   = drp_daddr;
        repeat (lat) cyc();
        drp_drdy = 1'b1; drp_do = data; cyc(); drp_drdy = 1'b0;
        v1 = sample_valid;
        cyc();
        v2 = sample_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1; ch_en = '0; eoc = 1'b0; drp_drdy = 1'b0; drp_do = '0;
        repeat (3) cyc();
        rst = 1'b0;
        n_cmp++; if (drp_den !== 1'b0) begin n_err++; $display("FAIL reset_den got %b want 0", drp_den); end
        n_cmp++; if (drp_daddr !== 7'h1E) begin n_err++; $display("FAIL reset_daddr got %h want 1e", drp_daddr); end
        n_cmp++; if (sample !== 48'h0) begin n_err++; $display("FAIL reset_sample got %h want 0", sample); end
        n_cmp++; if (sample_valid !== 4'h0) begin n_err++; $display("FAIL reset_valid got %b want 0000", sample_valid); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_tmo got %b want 0", timeout_err); end
        n_cmp++; if (pwm_out !== 4'h0) begin n_err++; $display("FAIL reset_pwm got %b want 0000", pwm_out); end
    endtask

    task automatic test_scan();
        logic [15:0] data [4] = '{16'h1230, 16'hABC0, 16'h4560, 16'h7890};
        logic [6:0]  eaddr [4] = '{7'h1E, 7'h16, 7'h1E, 7'h16};
        logic [3:0]  evld [4] = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
        int          ech [4] = '{0, 3, 0, 3};
        logic [6:0]  a;
        logic        d;
        logic [3:0]  v1, v2;
        go_idle_then(4'b1001);
        for (int k = 0; k < 4; k++) begin
            do_read(data[k], 3, a, d, v1, v2);
            n_cmp++; if (d !== 1'b1) begin n_err++; $display("FAIL scan_den[%0d] got %b want 1", k, d); end
            n_cmp++; if (a !== eaddr[k]) begin n_err++; $display("FAIL scan_addr[%0d] got %h want %h", k, a, eaddr[k]); end
            n_cmp++; if (v1 !== evld[k] || v2 !== 4'b0) begin
                n_err++; $display("FAIL scan_valid[%0d] got %b,%b want %b,0000", k, v1, v2, evld[k]);
            end
            n_cmp++; if (sample[12*ech[k] +: 12] !== data[k][15:4]) begin
                n_err++; $display("FAIL scan_sample[%0d] got %h want %h", k, sample[12*ech[k] +: 12], data[k][15:4]);
            end
        end
        n_cmp++; if (sample[12 +: 24] !== 24'h0) begin n_err++; $display("FAIL scan_untouched got %h want 0", sample[12 +: 24]); end
    endtask

    task automatic test_pwm();
        logic [6:0] a;
        logic       d;
        logic [3:0] v1, v2;
        int         hi = 0;
        logic [3:0] other = '0;
        go_idle_then(4'b0100);
        do_read(16'h8000, 2, a, d, v1, v2);
        n_cmp++; if (a !== 7'h1F || v1 !== 4'b0100) begin n_err++; $display("FAIL pwm_read got addr %h vld %b want 1f 0100", a, v1); end
        n_cmp++; if (sample[24 +: 12] !== 12'h800) begin n_err++; $display("FAIL pwm_sample got %h want 800", sample[24 +: 12]); end
        repeat (3) cyc();
        for (int k = 0; k < 4071; k++) begin
            cyc();
            hi += int'(pwm_out[2]);
            other |= pwm_out & 4'b1011;
        end
        n_cmp++; if (hi != 2048) begin n_err++; $display("FAIL pwm_duty got %0d want 2048", hi); end
        n_cmp++; if (other !== 4'b0) begin n_err++; $display("FAIL pwm_others got %b want 0000", other); end
    endtask

    task automatic test_mask();
        logic [6:0] a;
        logic       d;
        logic [3:0] v1, v2;
        int         hi = 0;
        go_idle_then(4'b0001);
        do_read(16'h00F0, 1, a, d, v1, v2);
        n_cmp++; if (sample[0 +: 12] !== 12'h00F) begin n_err++; $display("FAIL mask_sample got %h want 00f", sample[0 +: 12]); end
        for (int k = 0; k < 4071; k++) begin
            cyc();
            hi += int'(pwm_out[0]);
        end
        n_cmp++; if (hi != 0) begin n_err++; $display("FAIL mask_pwm got %0d high want 0", hi); end
    endtask

    task automatic test_timeout();
        int         n = 0;
        logic       vseen = 1'b0;
        logic [6:0] a;
        logic       d;
        logic [3:0] v1, v2;
        go_idle_then(4'b1001);
        cyc(); cyc();
        eoc = 1'b1; cyc(); eoc = 1'b0;
        n_cmp++; if (drp_den !== 1'b1 || drp_daddr !== 7'h1E) begin
            n_err++; $display("FAIL tmo_req got den %b addr %h want 1 1e", drp_den, drp_daddr);
        end
        while (timeout_err !== 1'b1 && n < 400) begin
            cyc();
            n++;
            if (|sample_valid) vseen = 1'b1;
        end
        n_cmp++; if (n != TMO + 1) begin n_err++; $display("FAIL tmo_latency got %0d want %0d", n, TMO + 1); end
        cyc();
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_width got %b want 0", timeout_err); end
        n_cmp++; if (vseen !== 1'b0 || sample[0 +: 12] !== 12'h00F) begin
            n_err++; $display("FAIL tmo_nocapture got vld %b s0 %h want 0 00f", vseen, sample[0 +: 12]);
        end
        do_read(16'h5550, 2, a, d, v1, v2);
        n_cmp++; if (a !== 7'h16 || v1 !== 4'b1000 || sample[36 +: 12] !== 12'h555) begin
            n_err++; $display("FAIL tmo_advance got addr %h vld %b s3 %h want 16 1000 555", a, v1, sample[36 +: 12]);
        end
    endtask

    task automatic test_disable_and_reset();
        int dens = 0;
        go_idle_then(4'b0001);
        cyc(); cyc();
        eoc = 1'b1; cyc(); eoc = 1'b0;
        n_cmp++; if (drp_den !== 1'b1) begin n_err++; $display("FAIL dis_den got %b want 1", drp_den); end
        cyc();
        ch_en = 4'b0; cyc();
        drp_drdy = 1'b1; drp_do = 16'hFFF0; cyc(); drp_drdy = 1'b0;
        n_cmp++; if (sample_valid !== 4'b0 || sample[0 +: 12] !== 12'h00F) begin
            n_err++; $display("FAIL dis_discard got vld %b s0 %h want 0000 00f", sample_valid, sample[0 +: 12]);
        end
        for (int k = 0; k < 8; k++) begin
            eoc = k[0];
            cyc();
            dens += int'(drp_den);
        end
        eoc = 1'b0;
        n_cmp++; if (dens != 0) begin n_err++; $display("FAIL dis_idle_den got %0d want 0", dens); end
        ch_en = 4'b1001;
        repeat (3) cyc();
        eoc = 1'b1; cyc(); eoc = 1'b0;
        rst = 1'b1; cyc(); rst = 1'b0;
        n_cmp++; if (drp_den !== 1'b0 || drp_daddr !== 7'h1E) begin
            n_err++; $display("FAIL rst_mid_drp got den %b addr %h want 0 1e", drp_den, drp_daddr);
        end
        n_cmp++; if (sample !== 48'h0 || sample_valid !== 4'b0 || pwm_out !== 4'b0 || timeout_err !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_out got s %h v %b p %b t %b want all 0", sample, sample_valid, pwm_out, timeout_err);
        end
    endtask

`ifdef XADC_SCAN_AVG_EN
    task automatic test_avg();
        logic [15:0] data [4] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
        logic [6:0]  a;
        logic        d;
        logic [3:0]  v1, v2;
        go_idle_then(4'b0001);
        for (int k = 0; k < 4; k++) begin
            do_read(data[k], 2, a, d, v1, v2);
            n_cmp++; if (v1 !== ((k == 3) ? 4'b0001 : 4'b0000)) begin
                n_err++; $display("FAIL avg_valid[%0d] got %b want %b", k, v1, (k == 3) ? 4'b0001 : 4'b0000);
            end
        end
        n_cmp++; if (sample[0 +: 12] !== 12'h280) begin n_err++; $display("FAIL avg_sample got %h want 280", sample[0 +: 12]); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef XADC_SCAN_AVG_EN
        test_avg();
`else
        test_scan();
        test_pwm();
        test_mask();
        test_timeout();
        test_disable_and_reset();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
